// File: rtl/ddr_frame_wr_sched_if.sv
// rtl/ddr_frame_wr_sched_if.sv - DDR write-port command/data handshake bundle
//
// Purpose: groups the burst write command channel and the write data channel
// between the frame scheduler (master) and the DDR UI adapter (slave).
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : one command per burst
//   wr_valid/wr_ready/wr_data/wr_last    : cmd_len data beats per burst
interface ddr_frame_wr_sched_if #(
  parameter int ADDR_W = 28
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [63:0]       wr_data;
  logic              wr_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, wr_last,
    input  cmd_ready, wr_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, wr_last,
    output cmd_ready, wr_ready
  );
endinterface

// File: rtl/ddr_frame_wr_sched.sv
// rtl/ddr_frame_wr_sched.sv - camera FIFO to DDR3 ping-pong frame write scheduler
//
// Purpose: waits until the camera FIFO holds a full burst, issues a write
// command and then streams the burst beats straight from the FWFT FIFO.
// Alternates between two frame banks and publishes the last completed bank.
// Ports:
//   clk, rst          : ui_clk and synchronous active-high reset
//   i_enable          : camera and DDR init complete
//   i_frame_start     : new camera frame pulse
//   i_fifo_rd_count   : FIFO words available
//   i_fifo_rd_data    : FWFT FIFO head word
//   o_fifo_rd_en      : FIFO pop (one per accepted beat)
//   ddr               : command + data write port (master side)
//   o_wr_bank/o_rd_bank, o_frame_done/o_frame_drop, o_busy : status
module ddr_frame_wr_sched #(
  parameter int                FRAME_WORDS = 76800,
  parameter int                BURST_LEN   = 64,
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BANK0_BASE  = 28'h000_0000,
  parameter logic [ADDR_W-1:0] BANK1_BASE  = 28'h020_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_frame_start,
  input  logic [10:0] i_fifo_rd_count,
  input  logic [63:0] i_fifo_rd_data,
  output logic        o_fifo_rd_en,
  ddr_frame_wr_sched_if.master ddr,
  output logic        o_wr_bank,
  output logic        o_rd_bank,
  output logic        o_frame_done,
  output logic        o_frame_drop,
  output logic        o_busy
);

  // At least 9 bits so BURST_LEN (up to 255) always fits for the min() compare.
  localparam int WCNT_W = ($clog2(FRAME_WORDS + 1) > 8) ? $clog2(FRAME_WORDS + 1) : 9;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_CMD, S_DATA, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_wr_bank, r_rd_bank;
  logic [ADDR_W-1:0]   r_addr, r_cmd_addr;
  logic [7:0]          r_cmd_len, r_bcnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_pend, r_drop;

  logic                w_drop, w_pend_next;
  logic                w_beat, w_last, w_frame_end, w_fifo_ok;
  logic [WCNT_W-1:0]   w_remain, w_wcnt_inc;
  logic [7:0]          w_len;

  assign w_beat      = (r_state == S_DATA) && ddr.wr_ready;
  assign w_last      = (r_state == S_DATA) && (r_bcnt == r_cmd_len - 8'd1);
  assign w_wcnt_inc  = r_wcnt + WCNT_W'(1);
  assign w_frame_end = (w_wcnt_inc == WCNT_W'(FRAME_WORDS));
  assign w_remain    = WCNT_W'(FRAME_WORDS) - r_wcnt;
  assign w_len       = (w_remain < WCNT_W'(BURST_LEN)) ? w_remain[7:0] : 8'(BURST_LEN);
  assign w_fifo_ok   = (i_fifo_rd_count >= {3'b000, w_len});

  always_comb begin
    w_next      = r_state;
    w_drop      = 1'b0;
    w_pend_next = r_pend | i_frame_start;
    case (r_state)
      S_IDLE: begin
        // frame_start is not latched while disabled; a leftover pending start
        // from a frame that ended on the same cycle launches the next frame.
        w_pend_next = r_pend;
        if (i_enable && (r_pend || i_frame_start)) begin
          w_next      = S_ARM;
          w_pend_next = 1'b0;
        end
      end
      S_ARM: w_next = S_WAIT;
      S_WAIT: begin
        if (!i_enable) begin
          w_next      = S_IDLE;
          w_drop      = (r_wcnt != '0);
          w_pend_next = 1'b0;
        end else if (r_pend || i_frame_start) begin
          w_next      = S_ARM;
          w_drop      = (r_wcnt != '0);
          w_pend_next = 1'b0;
        end else if (w_fifo_ok) begin
          w_next = S_CMD;
        end
      end
      S_CMD: if (ddr.cmd_ready) w_next = S_DATA;
      S_DATA: begin
        if (w_beat && w_last) begin
          // A start seen earlier in the burst wins over completion; a start on
          // the final beat itself lets the frame complete and stays pending.
          if (r_pend) begin
            w_next      = S_ARM;
            w_drop      = 1'b1;
            w_pend_next = 1'b0;
          end else if (!i_enable) begin
            w_next      = S_IDLE;
            w_drop      = 1'b1;
            w_pend_next = 1'b0;
          end else if (w_frame_end) begin
            w_next      = S_DONE;
            w_pend_next = i_frame_start;
          end else if (i_frame_start) begin
            w_next      = S_ARM;
            w_drop      = 1'b1;
            w_pend_next = 1'b0;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b1;
      r_addr     <= BANK0_BASE;
      r_cmd_addr <= BANK0_BASE;
      r_cmd_len  <= 8'd0;
      r_wcnt     <= '0;
      r_bcnt     <= 8'd0;
      r_pend     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_next;
      r_drop  <= w_drop;
      case (r_state)
        S_ARM: begin
          r_addr <= r_wr_bank ? BANK1_BASE : BANK0_BASE;
          r_wcnt <= '0;
        end
        S_WAIT: begin
          if (w_next == S_CMD) begin
            r_cmd_len  <= w_len;
            r_cmd_addr <= r_addr;
          end
        end
        S_CMD: if (ddr.cmd_ready) r_bcnt <= 8'd0;
        S_DATA: begin
          if (w_beat) begin
            r_bcnt <= r_bcnt + 8'd1;
            r_wcnt <= w_wcnt_inc;
            if (w_last) r_addr <= r_addr + ADDR_W'({r_cmd_len, 3'b000});
          end
        end
        S_DONE: begin
          r_rd_bank <= r_wr_bank;
          r_wr_bank <= ~r_wr_bank;
        end
        default: ;
      endcase
    end
  end

  assign ddr.cmd_valid = (r_state == S_CMD);
  assign ddr.cmd_addr  = r_cmd_addr;
  assign ddr.cmd_len   = r_cmd_len;
  assign ddr.wr_valid  = (r_state == S_DATA);
  assign ddr.wr_data   = i_fifo_rd_data;
  assign ddr.wr_last   = w_last;
  assign o_fifo_rd_en  = w_beat;
  assign o_wr_bank     = r_wr_bank;
  assign o_rd_bank     = r_rd_bank;
  assign o_frame_done  = (r_state == S_DONE);
  assign o_frame_drop  = r_drop;
  assign o_busy        = (r_state == S_CMD) || (r_state == S_DATA);

endmodule
